instr_stream_gen: RTL and testbench

INSTR_STREAM_GEN -- requirements
Module: instr_stream_gen

---
 rtl/instr_stream_gen_pkg.sv | 13 +
 rtl/instr_store.sv | 43 ++++
 rtl/instr_stream_gen.sv | 140 ++++++++++++++
 tb/tb_instr_stream_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_stream_gen_pkg.sv
// Shared constants for the instruction stream generator: default widths and
// FSM state encodings.
package instr_stream_gen_pkg;

  localparam int DEF_INSTR_W = 32;
  localparam int DEF_DEPTH   = 32;
  localparam int DEF_CNT_W   = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/instr_store.sv
// Program store: single write port, registered read port whose output register
// is the instruction word presented to the consumer.
module instr_store
  import instr_stream_gen_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic               i_re,
  input  logic [ADDR_W-1:0]  i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [INSTR_W-1:0] r_rdata;

  // NOTE: the array has no reset so it maps onto plain RAM; loaded programs
  // survive a reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // The read register holds its value when i_re is low, which keeps instr
  // stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_stream_gen.sv
// Instruction stream generator: issues prog_len stored words over a
// valid/ready port. Define STREAM_LOOP_EN to add the loop_en wrap-around mode.
module instr_stream_gen
  import instr_stream_gen_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ld_we,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [INSTR_W-1:0] ld_data,
  input  logic [ADDR_W:0]    prog_len,
  input  logic               start,
  input  logic               halt,
`ifdef STREAM_LOOP_EN
  input  logic               loop_en,
`endif
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  idx,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   issued_cnt
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

  logic [1:0]         r_state;
  logic [ADDR_W:0]    r_len;
  logic [ADDR_W-1:0]  r_idx;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_start;
  logic               w_xfer;
  logic               w_last;
  logic               w_loop;
  logic               w_we;
  logic               w_rd_en;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic [ADDR_W:0]    w_len;
  logic [INSTR_W-1:0] w_rd_data;

`ifdef STREAM_LOOP_EN
  logic r_loop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_loop <= 1'b0;
    end else if (w_start) begin
      r_loop <= loop_en;
    end
  end

  assign w_loop = r_loop;
`else
  assign w_loop = 1'b0;
`endif

  // Halt outranks start in every state; start is only honoured outside RUN.
  assign w_start = start && !halt && (r_state != ST_RUN);
  assign w_xfer  = (r_state == ST_RUN) && instr_ready;
  assign w_last  = ({1'b0, r_idx} == (r_len - (ADDR_W+1)'(1)));
  assign w_len   = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
  assign w_we    = ld_we && (r_state != ST_RUN);

  // NOTE: every combinational output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_rd_en   = 1'b0;
    w_rd_addr = r_idx + ADDR_W'(1);
    if (w_start) begin
      w_rd_en   = 1'b1;
      w_rd_addr = '0;
    end else if (w_xfer && !halt) begin
      if (!w_last) begin
        w_rd_en = 1'b1;
      end else if (w_loop) begin
        w_rd_en   = 1'b1;
        w_rd_addr = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else if (halt && (r_state != ST_IDLE)) begin
      r_state <= ST_IDLE;
    end else if (w_start) begin
      r_len   <= w_len;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_state <= (w_len == '0) ? ST_DONE : ST_RUN;
    end else if (w_xfer) begin
      if (r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_last && !w_loop) begin
        r_state <= ST_DONE;
      end else if (w_last) begin
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + ADDR_W'(1);
      end
    end
  end

  instr_store #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_store (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (ld_addr),
    .i_wdata (ld_data),
    .i_re    (w_rd_en),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  assign instr       = w_rd_data;
  assign instr_valid = (r_state == ST_RUN);
  assign idx         = r_idx;
  assign busy        = (r_state == ST_RUN);
  assign done        = (r_state == ST_DONE);
  assign issued_cnt  = r_cnt;

endmodule

// File: tb/tb_instr_stream_gen.sv
// Directed bench for instr_stream_gen; a second instance with a 3-bit counter
// shares the stimulus to exercise counter saturation in the default build.
module tb_instr_stream_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_we;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic [5:0]  prog_len;
  logic        start;
  logic        halt;
  logic        instr_ready;
`ifdef STREAM_LOOP_EN
  logic        loop_en;
`endif

  logic [31:0] instr;
  logic        instr_valid;
  logic [4:0]  idx;
  logic        busy;
  logic        done;
  logic [15:0] issued_cnt;

  logic [31:0] d2_instr;
  logic        d2_instr_valid;
  logic [4:0]  d2_idx;
  logic        d2_busy;
  logic        d2_done;
  logic [2:0]  d2_issued_cnt;

  logic [31:0] mem_tbl [32];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_xfer;

  always #5 clk = ~clk;

  instr_stream_gen #(.INSTR_W(32), .DEPTH(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .prog_len(prog_len), .start(start), .halt(halt),
`ifdef STREAM_LOOP_EN
    .loop_en(loop_en),
`endif
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .idx(idx), .busy(busy), .done(done), .issued_cnt(issued_cnt)
  );

  instr_stream_gen #(.INSTR_W(32), .DEPTH(32), .CNT_W(3)) dut2 (
    .clk(clk), .reset(reset), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .prog_len(prog_len), .start(start), .halt(halt),
`ifdef STREAM_LOOP_EN
    .loop_en(loop_en),
`endif
    .instr(d2_instr), .instr_valid(d2_instr_valid), .instr_ready(instr_ready),
    .idx(d2_idx), .busy(d2_busy), .done(d2_done), .issued_cnt(d2_issued_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    mem_tbl[0] = 32'h0020_0093;
    mem_tbl[1] = 32'h0050_0113;
    mem_tbl[2] = 32'h4020_81B3;
    mem_tbl[3] = 32'h0000_0013;
    for (int i = 4; i < 32; i++) mem_tbl[i] = 32'hA000_0000 + i;

    reset = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0; prog_len = '0;
    start = 1'b0; halt = 1'b0; instr_ready = 1'b0;
`ifdef STREAM_LOOP_EN
    loop_en = 1'b0;
`endif
    @(negedge clk); @(negedge clk);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_idx", idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt", issued_cnt, 0);
    reset = 1'b1;

    for (int i = 0; i < 32; i++) begin
      ld_we = 1'b1; ld_addr = 5'(i); ld_data = mem_tbl[i];
      @(negedge clk);
    end
    ld_we = 1'b0;
    check("idle_valid", instr_valid, 0);

    // Basic 4-word program with the consumer always ready
    prog_len = 6'd4; start = 1'b1; instr_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("run_valid", instr_valid, 1);
      check("run_busy", busy, 1);
      check("run_instr", instr, mem_tbl[k]);
      check("run_idx", idx, k);
      check("run_cnt", issued_cnt, k);
      @(negedge clk);
    end
    check("run_end_valid", instr_valid, 0);
    check("run_end_done", done, 1);
    check("run_end_busy", busy, 0);
    check("run_end_cnt", issued_cnt, 4);
    check("d2_run_cnt", d2_issued_cnt, 4);

    // Restart from DONE, stall three cycles at idx 1
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("rs_idx0", idx, 0);
    check("rs_cnt_clr", issued_cnt, 0);
    @(negedge clk);
    check("rs_idx1", idx, 1);
    check("rs_cnt1", issued_cnt, 1);
    instr_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall_valid", instr_valid, 1);
      check("stall_instr", instr, 32'h0050_0113);
      check("stall_idx", idx, 1);
      check("stall_cnt", issued_cnt, 1);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    check("post_idx2", idx, 2);
    check("post_cnt2", issued_cnt, 2);
    @(negedge clk);
    check("post_idx3", idx, 3);
    check("post_instr3", instr, 32'h0000_0013);
    @(negedge clk);
    check("post_done", done, 1);
    check("post_cnt4", issued_cnt, 4);

    // Halt out of DONE, then an empty program
    halt = 1'b1;
    @(negedge clk); halt = 1'b0;
    check("halt_done", done, 0);
    check("halt_busy", busy, 0);
    prog_len = 6'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("zero_done", done, 1);
    check("zero_valid", instr_valid, 0);
    check("zero_cnt", issued_cnt, 0);
    @(negedge clk);
    check("zero_valid2", instr_valid, 0);
    check("zero_busy2", busy, 0);

    // Oversized length clamps to the store depth; start and load in RUN ignored
    prog_len = 6'd40; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_xfer = 0;
    for (int k = 0; k < 40; k++) begin
      if (instr_valid) begin
        check("long_instr", instr, mem_tbl[k]);
        check("long_idx", idx, k);
        n_xfer++;
      end
      ld_we = (k == 3);
      ld_addr = 5'd20; ld_data = 32'hDEAD_BEEF;
      start = (k == 5);
      @(negedge clk);
    end
    ld_we = 1'b0; start = 1'b0;
    check("long_xfers", n_xfer, 32);
    check("long_cnt", issued_cnt, 32);
    check("long_done", done, 1);
    check("d2_sat_cnt", d2_issued_cnt, 7);

    // Halt with a simultaneous start at idx 2
    prog_len = 6'd4; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    check("hs_idx2", idx, 2);
    halt = 1'b1; start = 1'b1;
    @(negedge clk); halt = 1'b0; start = 1'b0;
    check("hs_valid", instr_valid, 0);
    check("hs_busy", busy, 0);
    check("hs_done", done, 0);
    check("hs_cnt", issued_cnt, 2);
    @(negedge clk);
    check("hs_stay_idle", busy, 0);

    // Reset in the middle of a run, then reissue
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("mr_idx1", idx, 1);
    reset = 1'b0;
    @(negedge clk);
    check("mr_valid", instr_valid, 0);
    check("mr_instr", instr, 0);
    check("mr_idx", idx, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_cnt", issued_cnt, 0);
    reset = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("mr_re_valid", instr_valid, 1);
    check("mr_re_idx", idx, 0);
    check("mr_re_instr", instr, 32'h0020_0093);
    check("mr_re_cnt", issued_cnt, 0);
    @(negedge clk);
    check("mr_re_idx1", idx, 1);
    check("mr_re_cnt1", issued_cnt, 1);
    halt = 1'b1;
    @(negedge clk); halt = 1'b0;

`ifdef STREAM_LOOP_EN
    // Loop mode: wrap after idx 2 and keep counting until saturation
    loop_en = 1'b1; prog_len = 6'd3; start = 1'b1;
    @(negedge clk); start = 1'b0; loop_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("loop_idx", idx, k % 3);
      check("loop_instr", instr, mem_tbl[k % 3]);
      check("loop_done", done, 0);
      @(negedge clk);
    end
    check("loop_cnt5", issued_cnt, 5);
    repeat (65535) @(negedge clk);
    check("loop_sat", issued_cnt, 32'hFFFF);
    check("loop_busy", busy, 1);
    check("loop_done_end", done, 0);
    halt = 1'b1;
    @(negedge clk); halt = 1'b0;
    check("loop_halt", busy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
